// File: rtl/rsa_host_sequencer_if.sv
// ---------------------------------------------------------------------------
// rsa_host_sequencer_if
//   Arm<->FPGA RSA command/data protocol bundle.
//   master : initiator (host sequencer) - drives cmd, data out, acknowledges
//   slave  : responder (RSA core wrapper)
//
//   cmd / cmd_valid : 32-bit command word, opcode in [2:0], 1-cycle strobe
//   done / done_read: responder completion flag and its 1-cycle acknowledge
//   tx_*            : host -> FPGA data beat (TX_SIZE bits)
//   rx_*            : FPGA -> host data beat (TX_SIZE bits)
// ---------------------------------------------------------------------------
interface rsa_host_sequencer_if #(
  parameter int TX_SIZE = 1024
);
  logic [31:0]        cmd;
  logic               cmd_valid;
  logic               done;
  logic               done_read;
  logic               tx_valid;
  logic               tx_ready;
  logic [TX_SIZE-1:0] tx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic [TX_SIZE-1:0] rx_data;

  modport master (
    output cmd, cmd_valid, done_read, tx_valid, tx_data, rx_ready,
    input  done, tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  cmd, cmd_valid, done_read, tx_valid, tx_data, rx_ready,
    output done, tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/rsa_host_sequencer.sv
// ---------------------------------------------------------------------------
// rsa_host_sequencer
//   Initiator end of the Arm<->FPGA RSA protocol. Takes one job on a
//   valid/ready port, runs the five protocol steps (load modulus, load
//   R^2/x, load exponent/Rmodm, compute, read result) and returns the
//   OP_W-bit result on a valid/ready port.
//
//   Ports
//     clk, resetn         : clock, asynchronous active-low reset
//     job_valid/job_ready : job handshake; job_mode 0 = modexp, 1 = montmul
//     job_mod, job_rmodm, job_rsqmodm, job_exp, job_x : operands
//     res_valid/res_ready : result handshake; res_data result, res_err abort
//     bus                 : protocol port (rsa_host_sequencer_if.master)
//
//   Optional feature (macro RSA_SEQ_TIMEOUT_EN): watchdog that aborts a job
//   stuck waiting on the responder for TIMEOUT_CYC cycles, returning
//   res_err = 1 with res_data = 0. Without the macro, waits are unbounded and
//   res_err is tied low.
// ---------------------------------------------------------------------------
module rsa_host_sequencer #(
  parameter int TX_SIZE     = 1024,
  parameter int OP_W        = 512,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            job_valid,
  output logic            job_ready,
  input  logic            job_mode,
  input  logic [OP_W-1:0] job_mod,
  input  logic [OP_W-1:0] job_rmodm,
  input  logic [OP_W-1:0] job_rsqmodm,
  input  logic [OP_W-1:0] job_exp,
  input  logic [OP_W-1:0] job_x,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [OP_W-1:0] res_data,
  output logic            res_err,
  rsa_host_sequencer_if.master bus
);

  if (TX_SIZE != 2 * OP_W || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("rsa_host_sequencer: TX_SIZE must equal 2*OP_W and TIMEOUT_CYC must be >= 2");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, SEND, RECV, WDONE, DRAIN, OUT} state_t;

  state_t          state;
  logic [2:0]      step;
  logic            mode_r;
  logic [OP_W-1:0] mod_r, rmodm_r, rsq_r, exp_r, x_r;
  logic            timeout_hit;

  // Opcode of each step; step 3 depends on the job mode.
  function automatic logic [2:0] step_op(input logic [2:0] s, input logic m);
    case (s)
      3'd0:    step_op = 3'd2;
      3'd1:    step_op = 3'd3;
      3'd2:    step_op = 3'd4;
      3'd3:    step_op = m ? 3'd1 : 3'd6;
      default: step_op = 3'd5;
    endcase
  endfunction

  // Data word sent in the SEND phase of steps 0..2; zero for the others.
  function automatic logic [TX_SIZE-1:0] step_tx(input logic [2:0] s,
      input logic [OP_W-1:0] m, rsq, x, e, rm);
    logic [TX_SIZE-1:0] t;
    t = '0;
    case (s)
      3'd0:    t[OP_W-1:0] = m;
      3'd1:    t = {x, rsq};
      3'd2:    t = {rm, e};
      default: t = '0;
    endcase
    return t;
  endfunction

  // The responder leaves its write state on rx_ready alone, so ready is only
  // ever an echo of valid inside RECV and can never precede it.
  assign bus.rx_ready = (state == RECV) && bus.rx_valid && !timeout_hit;

  // NOTE: every register below, including the wide operand and data
  // registers, is cleared by reset so a mid-job reset leaves no stale job
  // or data on the bus.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      step          <= '0;
      job_ready     <= 1'b0;
      mode_r        <= 1'b0;
      mod_r         <= '0;
      rmodm_r       <= '0;
      rsq_r         <= '0;
      exp_r         <= '0;
      x_r           <= '0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      bus.cmd       <= '0;
      bus.cmd_valid <= 1'b0;
      bus.done_read <= 1'b0;
      bus.tx_valid  <= 1'b0;
      bus.tx_data   <= '0;
    end else if (timeout_hit) begin
      // Abort: drop every protocol strobe and report an invalid result.
      bus.tx_valid  <= 1'b0;
      bus.done_read <= 1'b0;
      res_data      <= '0;
      res_valid     <= 1'b1;
      state         <= OUT;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // branch sees the register values from the start of the cycle.
      case (state)
        IDLE: begin
          if (job_valid && job_ready) begin
            job_ready     <= 1'b0;
            mode_r        <= job_mode;
            mod_r         <= job_mod;
            rmodm_r       <= job_rmodm;
            rsq_r         <= job_rsqmodm;
            exp_r         <= job_exp;
            x_r           <= job_x;
            step          <= 3'd0;
            // Step 0 is issued straight from the job inputs so the command
            // strobe follows the accept cycle without a bubble.
            bus.cmd       <= {29'd0, step_op(3'd0, job_mode)};
            bus.tx_data   <= step_tx(3'd0, job_mod, job_rsqmodm, job_x, job_exp, job_rmodm);
            bus.cmd_valid <= 1'b1;
            state         <= ISSUE;
          end else begin
            job_ready <= 1'b1;
          end
        end
        ISSUE: begin
          bus.cmd_valid <= 1'b0;
          case (step)
            3'd0, 3'd1, 3'd2: state <= SEND;
            3'd3:             state <= WDONE;
            default:          state <= RECV;
          endcase
        end
        SEND: begin
          // tx_valid rises the cycle after tx_ready is seen, for one cycle.
          if (bus.tx_valid) begin
            bus.tx_valid <= 1'b0;
            state        <= WDONE;
          end else if (bus.tx_ready) begin
            bus.tx_valid <= 1'b1;
          end
        end
        RECV: begin
          if (bus.rx_valid) begin
            res_data <= bus.rx_data[OP_W-1:0];
            state    <= WDONE;
          end
        end
        WDONE: begin
          if (bus.done) begin
            bus.done_read <= 1'b1;
            state         <= DRAIN;
          end
        end
        DRAIN: begin
          // done lags the responder's state by a cycle; waiting for it to
          // fall keeps one completion from being acknowledged twice.
          bus.done_read <= 1'b0;
          if (!bus.done) begin
            if (step == 3'd4) begin
              res_valid <= 1'b1;
              state     <= OUT;
            end else begin
              step          <= step + 3'd1;
              bus.cmd       <= {29'd0, step_op(step + 3'd1, mode_r)};
              bus.tx_data   <= step_tx(step + 3'd1, mod_r, rsq_r, x_r, exp_r, rmodm_r);
              bus.cmd_valid <= 1'b1;
              state         <= ISSUE;
            end
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RSA_SEQ_TIMEOUT_EN
  state_t      state_q;
  logic [31:0] tmo_cnt;
  logic        waiting;

  assign waiting = (state == SEND) || (state == RECV) || (state == WDONE) || (state == DRAIN);

  // tmo_cnt holds (cycles spent in the current state - 1); on the first
  // cycle of a state it still holds the previous state's count, so the
  // compare is masked until state_q catches up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state_q <= state;
      if (!waiting)              tmo_cnt <= '0;
      else if (state != state_q) tmo_cnt <= 32'd1;
      else                       tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign timeout_hit = waiting && (state == state_q) && (tmo_cnt >= 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                           res_err <= 1'b0;
    else if (timeout_hit)                  res_err <= 1'b1;
    else if (state == OUT && res_ready)    res_err <= 1'b0;
  end
`else
  assign timeout_hit = 1'b0;
  assign res_err     = 1'b0;
`endif

  // Only the low OP_W bits of a returned beat carry the result.
  logic unused_rx_hi;
  assign unused_rx_hi = ^bus.rx_data[TX_SIZE-1:OP_W];

endmodule

// File: tb/tb_rsa_host_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rsa_host_sequencer
//   Directed job sequence with random operands and random responder data.
//   The bench plays the responder and predicts the command/data stream from
//   the job (opcode list and data words per step) and the result from the
//   word it returns on the rx port.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rsa_host_sequencer;
  localparam int OP_W    = 512;
  localparam int TX_SIZE = 1024;
  localparam int LIMIT   = 300;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            job_valid, job_ready, job_mode;
  logic [OP_W-1:0] job_mod, job_rmodm, job_rsqmodm, job_exp, job_x;
  logic            res_valid, res_ready, res_err;
  logic [OP_W-1:0] res_data;

  rsa_host_sequencer_if #(.TX_SIZE(TX_SIZE)) bus ();

  rsa_host_sequencer #(.TX_SIZE(TX_SIZE), .OP_W(OP_W), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .resetn(resetn),
    .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode),
    .job_mod(job_mod), .job_rmodm(job_rmodm), .job_rsqmodm(job_rsqmodm),
    .job_exp(job_exp), .job_x(job_x),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected protocol stream for the job in flight.
  logic [31:0]     exp_op [5];
  logic [OP_W-1:0] exp_lo [3];
  logic [OP_W-1:0] exp_hi [3];

  task automatic check(input string tag, input logic [OP_W-1:0] obs, input logic [OP_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OP_W-1:0] rand_op();
    logic [OP_W-1:0] v;
    for (int i = 0; i < OP_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic start_job(input logic mode, input logic [OP_W-1:0] m, rsq, x, e, rm);
    int n;
    exp_op[0] = 32'd2; exp_op[1] = 32'd3; exp_op[2] = 32'd4;
    exp_op[3] = mode ? 32'd1 : 32'd6; exp_op[4] = 32'd5;
    exp_lo[0] = m;   exp_hi[0] = '0;
    exp_lo[1] = rsq; exp_hi[1] = x;
    exp_lo[2] = e;   exp_hi[2] = rm;
    job_mode = mode; job_mod = m; job_rsqmodm = rsq; job_x = x; job_exp = e; job_rmodm = rm;
    job_valid = 1'b1;
    n = 0;
    while (job_ready !== 1'b1 && n < LIMIT) begin tick(); n++; end
    check("job_ready_idle", job_ready, 1);
    tick();
    // Scramble the inputs: the sequencer must run from its latched copy.
    job_valid = 1'b0; job_mode = ~mode;
    job_mod = rand_op(); job_rsqmodm = rand_op(); job_x = rand_op();
    job_exp = rand_op(); job_rmodm = rand_op();
    check("job_ready_drop", job_ready, 0);
  endtask

  task automatic wait_cmd(input int i);
    int n;
    n = 0;
    while (bus.cmd_valid !== 1'b1 && n < LIMIT) begin tick(); n++; end
    check($sformatf("s%0d_cmd_valid", i), bus.cmd_valid, 1);
    check($sformatf("s%0d_cmd", i), bus.cmd, exp_op[i]);
    if (i < 3) begin
      check($sformatf("s%0d_tx_lo_issue", i), bus.tx_data[OP_W-1:0], exp_lo[i]);
      check($sformatf("s%0d_tx_hi_issue", i), bus.tx_data[TX_SIZE-1:OP_W], exp_hi[i]);
    end
    tick();
    check($sformatf("s%0d_cmd_pulse", i), bus.cmd_valid, 0);
  endtask

  task automatic respond_step(input int i, input int tx_dly, input int rx_dly,
                              input int done_hold, input logic [TX_SIZE-1:0] rx_word);
    logic bad;
    int   reads;
    wait_cmd(i);
    if (i < 3) begin
      bad = 1'b0;
      for (int k = 0; k < tx_dly; k++) begin
        if (bus.tx_valid !== 1'b0) bad = 1'b1;
        tick();
      end
      if (bus.tx_valid !== 1'b0) bad = 1'b1;
      check($sformatf("s%0d_tx_before_ready", i), bad, 0);
      bus.tx_ready = 1'b1;
      tick();
      check($sformatf("s%0d_tx_valid", i), bus.tx_valid, 1);
      check($sformatf("s%0d_tx_lo", i), bus.tx_data[OP_W-1:0], exp_lo[i]);
      check($sformatf("s%0d_tx_hi", i), bus.tx_data[TX_SIZE-1:OP_W], exp_hi[i]);
      tick();
      bus.tx_ready = 1'b0;
      check($sformatf("s%0d_tx_one_beat", i), bus.tx_valid, 0);
    end else if (i == 4) begin
      bad = 1'b0;
      for (int k = 0; k < rx_dly; k++) begin
        if (bus.rx_ready !== 1'b0) bad = 1'b1;
        tick();
      end
      check("rx_ready_before_valid", bad, 0);
      bus.rx_data  = rx_word;
      bus.rx_valid = 1'b1;
      #1;
      check("rx_ready_with_valid", bus.rx_ready, 1);
      tick();
      bus.rx_valid = 1'b0;
      #1;
      check("rx_one_beat", bus.rx_ready, 0);
    end
    tick();
    bus.done = 1'b1;
    tick();
    check($sformatf("s%0d_done_read", i), bus.done_read, 1);
    reads = 1;
    bad   = 1'b0;
    for (int k = 0; k < done_hold; k++) begin
      tick();
      if (bus.done_read === 1'b1) reads++;
      if (bus.cmd_valid === 1'b1) bad = 1'b1;
    end
    bus.done = 1'b0;
    tick();
    if (bus.done_read === 1'b1) reads++;
    check($sformatf("s%0d_done_read_count", i), reads, 1);
    if (done_hold > 0) check($sformatf("s%0d_cmd_while_done", i), bad, 0);
  endtask

  task automatic finish_job(input logic [OP_W-1:0] exp_res, input int res_wait);
    int   n;
    logic bad;
    n = 0;
    while (res_valid !== 1'b1 && n < LIMIT) begin tick(); n++; end
    check("res_valid", res_valid, 1);
    check("res_data", res_data, exp_res);
    check("res_err", res_err, 0);
    check("job_ready_busy", job_ready, 0);
    bad = 1'b0;
    for (int k = 0; k < res_wait; k++) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== exp_res || job_ready !== 1'b0) bad = 1'b1;
    end
    if (res_wait > 0) check("res_hold_stable", bad, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_valid_drop", res_valid, 0);
    check("job_ready_after_res", job_ready, 1);
  endtask

  task automatic run_job(input logic mode, input logic [OP_W-1:0] m, rsq, x, e, rm,
                         input int tx_dly, input int rx_dly, input int done_hold, input int res_wait);
    logic [TX_SIZE-1:0] rx_word;
    rx_word = {rand_op(), rand_op()};
    start_job(mode, m, rsq, x, e, rm);
    for (int i = 0; i < 5; i++) respond_step(i, tx_dly, rx_dly, done_hold, rx_word);
    finish_job(rx_word[OP_W-1:0], res_wait);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic bad;
    int   n;
    job_valid = 1'b0; job_mode = 1'b0; res_ready = 1'b0;
    job_mod = '0; job_rmodm = '0; job_rsqmodm = '0; job_exp = '0; job_x = '0;
    bus.done = 1'b0; bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;

    // Reset values.
    repeat (3) tick();
    check("rst_job_ready", job_ready, 0);
    check("rst_cmd", bus.cmd, 0);
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_tx_data_lo", bus.tx_data[OP_W-1:0], 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    resetn = 1'b1;
    tick();
    check("idle_job_ready", job_ready, 1);

    // Stray done / rx_valid while idle are ignored.
    bus.done = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = {rand_op(), rand_op()};
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.rx_ready !== 1'b0 || bus.done_read !== 1'b0 || bus.cmd_valid !== 1'b0) bad = 1'b1;
    end
    check("idle_ignores_inputs", bad, 0);
    bus.done = 1'b0; bus.rx_valid = 1'b0;
    tick();

    // Directed mode-0 job.
    run_job(1'b0, 512'hF1, 512'h2A, 512'h05, 512'h11, 512'h0F, 2, 3, 0, 0);
    // Mode-1 job: only the step-3 opcode changes.
    run_job(1'b1, rand_op(), rand_op(), rand_op(), rand_op(), rand_op(), 1, 1, 0, 0);
    // done held high after done_read.
    run_job(1'b0, rand_op(), rand_op(), rand_op(), rand_op(), rand_op(), 0, 0, 2, 0);
    // Slow responder.
    run_job(1'b1, rand_op(), rand_op(), rand_op(), rand_op(), rand_op(), 50, 30, 0, 0);
    // Slow result consumer.
    run_job(1'b0, rand_op(), rand_op(), rand_op(), rand_op(), rand_op(), 1, 2, 1, 10);

    // Reset during step 2 SEND, with tx_valid up.
    start_job(1'b0, rand_op(), rand_op(), rand_op(), rand_op(), rand_op());
    respond_step(0, 1, 0, 0, '0);
    respond_step(1, 1, 0, 0, '0);
    wait_cmd(2);
    bus.tx_ready = 1'b1;
    tick();
    check("s2_tx_valid_pre_reset", bus.tx_valid, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_tx_valid", bus.tx_valid, 0);
    check("mid_rst_cmd_valid", bus.cmd_valid, 0);
    check("mid_rst_done_read", bus.done_read, 0);
    check("mid_rst_rx_ready", bus.rx_ready, 0);
    check("mid_rst_cmd", bus.cmd, 0);
    check("mid_rst_tx_data_hi", bus.tx_data[TX_SIZE-1:OP_W], 0);
    check("mid_rst_job_ready", job_ready, 0);
    bus.tx_ready = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    // Fresh job restarts from opcode 2.
    run_job(1'b0, rand_op(), rand_op(), rand_op(), rand_op(), rand_op(), 3, 4, 0, 0);

`ifdef RSA_SEQ_TIMEOUT_EN
    // Responder never answers the data phase: watchdog aborts the job.
    start_job(1'b1, rand_op(), rand_op(), rand_op(), rand_op(), rand_op());
    wait_cmd(0);
    n = 0;
    bad = 1'b0;
    while (res_valid !== 1'b1 && n < LIMIT) begin
      if (bus.tx_valid !== 1'b0 || bus.cmd_valid !== 1'b0) bad = 1'b1;
      tick();
      n++;
    end
    check("tmo_res_valid", res_valid, 1);
    check("tmo_res_err", res_err, 1);
    check("tmo_res_data", res_data, 0);
    check("tmo_latency_window", (n >= 90 && n <= 110), 1);
    check("tmo_no_pulses", bad, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("tmo_job_ready", job_ready, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
